playback_sample_streamer: RTL and testbench

Consumer-side partner to the SD track loader. It accepts 8-bit samples from the loader over a valid/ready stream and buffers them in a small FIFO. It releases exactly one sample per I2S frame, paced by the transmitter's word-select clock, so that stored tracks play back at the audio frame rate. It sits in the clk_100 domain, between track storage and the I2S transmitter's data input.

---
 rtl/playback_sample_streamer.sv | 134 +++++++++++++
 tb/tb_playback_sample_streamer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/playback_sample_streamer.sv
// Sample FIFO between track storage and the I2S transmitter: accepts samples over
// valid/ready and releases one per I2S frame, paced by the transmitter's word-select.
module playback_sample_streamer #(
  parameter int WORD_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          play_en,
  input  logic                          ws,
  input  logic [WORD_WIDTH-1:0]         din,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic [WORD_WIDTH-1:0]         sample_out,
  output logic                          sample_strobe,
  output logic                          playing,
  output logic                          underrun,
  output logic [7:0]                    underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, PRIME, PLAY} state_t;

  state_t                state_reg, state_next;
  logic                  ws_meta_reg, ws_s_reg, ws_d_reg;
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]         level_reg;
  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] rd_data_reg;
  logic [WORD_WIDTH-1:0] sample_reg;
  logic                  strobe_reg;
  logic                  pop_pending_reg, mute_pending_reg;
  logic                  underrun_reg;
  logic [7:0]            underrun_count_reg;
  logic                  frame_tick, push, pop, underrun_hit;

  // Falling edge of the synchronized word-select marks the start of the left word.
  assign frame_tick   = ws_d_reg & ~ws_s_reg;
  assign din_ready    = (state_reg != IDLE) && (level_reg < LW'(FIFO_DEPTH));
  assign push         = din_valid & din_ready;
  assign pop          = (state_reg == PLAY) && frame_tick && (level_reg != '0);
  assign underrun_hit = (state_reg == PLAY) && frame_tick && (level_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (!play_en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = PRIME;
        PRIME:   if (level_reg >= LW'(PRIME_LEVEL)) state_next = PLAY;
        PLAY:    state_next = PLAY;
        default: state_next = IDLE;
      endcase
    end
  end

  // Storage with registered read; the head word lands in rd_data_reg on the pop edge
  // and reaches sample_out one edge later.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
    rd_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_meta_reg        <= 1'b1;
      ws_s_reg           <= 1'b1;
      ws_d_reg           <= 1'b1;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      level_reg          <= '0;
      sample_reg         <= '0;
      strobe_reg         <= 1'b0;
      pop_pending_reg    <= 1'b0;
      mute_pending_reg   <= 1'b0;
      underrun_reg       <= 1'b0;
      underrun_count_reg <= '0;
    end else begin
      ws_meta_reg <= ws;
      ws_s_reg    <= ws_meta_reg;
      ws_d_reg    <= ws_s_reg;
      if (!play_en) begin
        // Flush discards any push in flight and any pending frame output.
        wr_ptr_reg       <= '0;
        rd_ptr_reg       <= '0;
        level_reg        <= '0;
        sample_reg       <= '0;
        strobe_reg       <= 1'b0;
        pop_pending_reg  <= 1'b0;
        mute_pending_reg <= 1'b0;
      end else begin
        if (state_reg == IDLE) begin
          underrun_reg       <= 1'b0;
          underrun_count_reg <= '0;
        end
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push, pop})
          2'b10:   level_reg <= level_reg + 1'b1;
          2'b01:   level_reg <= level_reg - 1'b1;
          default: level_reg <= level_reg;
        endcase
        pop_pending_reg  <= pop;
        mute_pending_reg <= underrun_hit;
        strobe_reg       <= pop_pending_reg | mute_pending_reg;
        if (pop_pending_reg) begin
          sample_reg <= rd_data_reg;
        end else if (mute_pending_reg) begin
          sample_reg   <= '0;
          underrun_reg <= 1'b1;
          if (underrun_count_reg != 8'hFF) underrun_count_reg <= underrun_count_reg + 8'd1;
        end
      end
    end
  end

  assign sample_out     = sample_reg;
  assign sample_strobe  = strobe_reg;
  assign playing        = (state_reg == PLAY);
  assign underrun       = underrun_reg;
  assign underrun_count = underrun_count_reg;
  assign fifo_level     = level_reg;

endmodule

// File: tb/tb_playback_sample_streamer.sv
// Scoreboard bench for playback_sample_streamer: expected samples are queued when a
// frame is driven and compared whenever the DUT strobes a sample.
module tb_playback_sample_streamer;

  logic       clk = 1'b0;
  logic       rst, play_en, ws, din_valid;
  logic [7:0] din;
  logic       din_ready, sample_strobe, playing, underrun;
  logic [7:0] sample_out, underrun_count;
  logic [4:0] fifo_level;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_ucnt = 0;
  logic [7:0] mdl[$];
  logic [7:0] exp_q[$];

  playback_sample_streamer #(.WORD_WIDTH(8), .FIFO_DEPTH(16), .PRIME_LEVEL(8)) dut (
    .clk(clk), .rst(rst), .play_en(play_en), .ws(ws),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .playing(playing),
    .underrun(underrun), .underrun_count(underrun_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: one line per strobed sample, compared against the scoreboard.
  always @(negedge clk) begin
    if (sample_strobe) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_strobe", 32'(sample_strobe), 32'd0);
      end else begin
        $display("[TB] strobe sample_out=%02h expected=%02h", sample_out, exp_q[0]);
        check_eq("sample", 32'(sample_out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sample_out"}, 32'(sample_out), 32'd0);
    check_eq({tag, "_strobe"},     32'(sample_strobe), 32'd0);
    check_eq({tag, "_playing"},    32'(playing), 32'd0);
    check_eq({tag, "_underrun"},   32'(underrun), 32'd0);
    check_eq({tag, "_ucount"},     32'(underrun_count), 32'd0);
    check_eq({tag, "_level"},      32'(fifo_level), 32'd0);
    check_eq({tag, "_din_ready"},  32'(din_ready), 32'd0);
  endtask

  task automatic push_word(input logic [7:0] v, input bit exp_rdy);
    @(negedge clk);
    din = v;
    din_valid = 1'b1;
    check_eq("din_ready", 32'(din_ready), 32'(exp_rdy));
    if (exp_rdy) mdl.push_back(v);
  endtask

  task automatic push_stop;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // One I2S frame: ws low for 'half' cycles then high. The falling edge is first
  // sampled at the edge following the drive, so the strobe appears after edge N+3.
  task automatic frame(input int half, input bit do_push, input logic [7:0] pv);
    logic [7:0] e;
    @(negedge clk);
    ws = 1'b0;
    if (mdl.size() != 0) begin
      e = mdl.pop_front();
    end else begin
      e = 8'h00;
      if (exp_ucnt < 255) exp_ucnt++;
    end
    exp_q.push_back(e);
    for (int i = 1; i <= half; i++) begin
      @(negedge clk);
      if (i == 2 && do_push) begin
        din = pv;
        din_valid = 1'b1;
        check_eq("sim_push_ready", 32'(din_ready), 32'd1);
        mdl.push_back(pv);
      end
      if (i == 3) begin
        din_valid = 1'b0;
        check_eq("strobe_latency", 32'(sample_strobe), 32'd0);
      end
      if (i == 4) check_eq("strobe_pulse", 32'(sample_strobe), 32'd1);
      if (i == 5) check_eq("strobe_width", 32'(sample_strobe), 32'd0);
    end
    ws = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; play_en = 1'b0; ws = 1'b1; din_valid = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Prime and start
    rst = 1'b0;
    play_en = 1'b1;
    for (int k = 1; k <= 8; k++) push_word(8'(k), 1'b1);
    push_stop();
    check_eq("prime_level", 32'(fifo_level), 32'd8);
    check_eq("prime_not_playing", 32'(playing), 32'd0);
    @(negedge clk);
    check_eq("playing_start", 32'(playing), 32'd1);
    for (int k = 0; k < 3; k++) frame(32, 1'b0, 8'h00);
    check_eq("level_after_3", 32'(fifo_level), 32'd5);

    // Push coincident with the frame tick
    frame(32, 1'b1, 8'h09);
    check_eq("sim_level", 32'(fifo_level), 32'd5);

    // Underrun: 5 stored samples over 7 frames
    for (int k = 0; k < 7; k++) frame(32, 1'b0, 8'h00);
    check_eq("ur_flag", 32'(underrun), 32'd1);
    check_eq("ur_count", 32'(underrun_count), 32'(exp_ucnt));
    check_eq("ur_playing", 32'(playing), 32'd1);
    push_word(8'h55, 1'b1);
    push_stop();
    frame(32, 1'b0, 8'h00);
    check_eq("ur_sticky", 32'(underrun), 32'd1);

    // Backpressure at full
    for (int k = 0; k < 16; k++) push_word(8'hA0 + 8'(k), 1'b1);
    push_word(8'hB0, 1'b0);
    push_stop();
    check_eq("full_level", 32'(fifo_level), 32'd16);
    frame(32, 1'b0, 8'h00);
    push_word(8'hB1, 1'b1);
    push_word(8'hB2, 1'b0);
    push_stop();
    check_eq("refill_level", 32'(fifo_level), 32'd16);
    for (int k = 0; k < 10; k++) frame(32, 1'b0, 8'h00);
    check_eq("drain_level", 32'(fifo_level), 32'd6);

    // Stop and restart
    @(negedge clk);
    play_en = 1'b0;
    @(negedge clk);
    check_eq("stop_level", 32'(fifo_level), 32'd0);
    check_eq("stop_sample", 32'(sample_out), 32'd0);
    check_eq("stop_ready", 32'(din_ready), 32'd0);
    check_eq("stop_playing", 32'(playing), 32'd0);
    check_eq("stop_ur_held", 32'(underrun), 32'd1);
    check_eq("stop_ucount_held", 32'(underrun_count), 32'(exp_ucnt));
    mdl.delete();
    play_en = 1'b1;
    exp_ucnt = 0;
    @(negedge clk);
    check_eq("restart_ur", 32'(underrun), 32'd0);
    check_eq("restart_ucount", 32'(underrun_count), 32'd0);
    check_eq("restart_ready", 32'(din_ready), 32'd1);
    check_eq("restart_playing", 32'(playing), 32'd0);

    // Saturation of the underrun counter
    for (int k = 0; k < 8; k++) push_word(8'h10 + 8'(k), 1'b1);
    push_stop();
    @(negedge clk);
    check_eq("sat_playing", 32'(playing), 32'd1);
    for (int k = 0; k < 308; k++) frame(8, 1'b0, 8'h00);
    check_eq("sat_count", 32'(underrun_count), 32'(exp_ucnt));
    check_eq("sat_flag", 32'(underrun), 32'd1);

    // Reset mid-frame with play_en held high
    @(negedge clk);
    ws = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_prime_ready", 32'(din_ready), 32'd1);
    check_eq("midrst_playing", 32'(playing), 32'd0);
    ws = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
